ex_stage_md: RTL and testbench
==============================

Name: ex_stage_md

Overview:
- Parametrised execute stage for the in-order scalar pipeline, sitting between the decode stage (DS) and the memory stage (MS).
- Latches one instruction per handshake and evaluates integer ALU ops in one cycle.
- Runs signed/unsigned div/mod on an embedded radix-2 iterative divider and stalls the pipe until it finishes.
- Drives the data SRAM with sub-word byte enables and lane-replicated write data.

Parameters:
- DW, 32: datapath width; must be 32 or 64.
- DIV_EN_W, 1: 1 instantiates the divider; 0 means div/mod ops return 0 with no stall.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- ms_allowin  in  1  MS can accept.
- es_allowin  out  1  ES can accept.
- ds_to_es_valid  in  1  DS offers an instruction.
- ds_op  in  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 10 div, 11 divu, 12 mod, 13 modu; 14/15 behave as add.
- ds_src1, ds_src2  in  DW  operands.
- ds_store_data  in  DW  store data.
- ds_mem_we, ds_res_from_mem  in  1  store / load.
- ds_mem_size  in  2  0 byte, 1 half, 2 word, 3 dword (DW=64 only).
- ds_rf_we  in  1  writeback enable.
- ds_rf_waddr  in  5  writeback register.
- ds_pc  in  32  PC.
- es_flush  in  1  kill the ES instruction.
- es_to_ms_valid  out  1  result valid to MS.
- es_result  out  DW  ALU/div result, or memory address for mem ops.
- es_rf_we  out  1  writeback enable, qualified by es_valid.
- es_rf_waddr  out  5  writeback register.
- es_res_from_mem  out  1  load flag.
- es_pc  out  32  PC.
- es_div_busy  out  1  divider not IDLE.
- data_sram_en  out  1  SRAM enable.
- data_sram_we  out  DW/8  byte write enables.
- data_sram_addr  out  32  byte address.
- data_sram_wdata  out  DW  write data.

Behaviour:
- Reset: es_valid=0, all pipeline regs=0, divider IDLE. All outputs are 0 except es_allowin=1.
- Handshake:
  - es_allowin = !es_valid | (es_ready_go & ms_allowin).
  - Load on ds_to_es_valid & es_allowin.
  - es_valid <= ds_to_es_valid when es_allowin.
  - es_to_ms_valid = es_valid & es_ready_go & !es_flush.
- es_flush: es_valid <= 0 next cycle and the divider returns to IDLE. Flush has priority over a simultaneous load, and es_allowin is forced to 0 that cycle.
- ALU ops:
  - Single-cycle; es_ready_go=1.
  - Shift amount = src2[log2(DW)-1:0].
  - slt/sltu produce 1 or 0 zero-extended.
- Divider FSM, for ops 10..13:
  - IDLE -> BUSY the cycle after es_valid rises (entry cycle E). At the transition it latches |src1|, |src2| and the result signs, and clears the counter.
  - BUSY runs DW cycles (E+1..E+DW), one restoring step per cycle.
  - BUSY -> DONE after DW steps, with sign-corrected quotient/remainder registered. DONE sets es_ready_go=1, so es_to_ms_valid first appears at E+DW+1.
  - DONE -> IDLE on es_to_ms_valid & ms_allowin. DONE holds with a stable result while ms_allowin=0 and never restarts.
  - While not DONE, es_ready_go=0.
- Divide semantics:
  - Quotient sign = sign1^sign2; remainder sign = sign1.
  - Divisor 0: quotient all-ones, remainder = src1.
  - MIN/-1: quotient MIN, remainder 0.
- Memory ops: address = src1+src2 (low 32 bits) = es_result; data_sram_en = es_valid & (mem_we | res_from_mem) & !es_flush.
- Store byte enables:
  - Byte: one-hot at addr lane.
  - Half: 2'b11 at the aligned half.
  - Word: 4'hF, or 8'h0F/8'hF0 when DW=64.
  - Dword: all ones.
  - Loads: data_sram_we = 0.
- Write data: the low byte/half/word of store_data is replicated across all lanes.
- Enable firing: data_sram_en is asserted only on the first cycle of es_valid for an instruction, so a store is never written twice under an MS stall. This uses a "mem_issued" flag cleared on each new load.

Optional Feature:
- Macro EX_ALE_EN.
- Defined:
  - Adds output es_ale (1 bit), which is high when es_valid and a mem op address is misaligned for its size.
  - Misaligned means half addr[0]!=0, word addr[1:0]!=0, dword addr[2:0]!=0.
  - When es_ale is high, data_sram_en=0 and es_rf_we=0; the instruction still passes to MS.
- Undefined: the port is absent and misaligned accesses are issued unchecked with the enables above.

Test Plan:
- add src1=5, src2=7, ms_allowin=1: es_result=12 and es_to_ms_valid=1 in the cycle es_valid rises; a back-to-back sub 3-5 gives 0xFFFFFFFE next cycle.
- div -7/2 (DW=32) entering at cycle E: es_div_busy for E+1..E+32, es_to_ms_valid first at E+33, es_result=0xFFFFFFFD; mod gives 0xFFFFFFFF; es_allowin=0 throughout.
- divu 0x10/0: es_result=0xFFFFFFFF; modu 0x10/0 gives 0x10; div 0x80000000/0xFFFFFFFF gives 0x80000000.
- store half, addr=0x1002, data=0xABCD1234: data_sram_we=4'b1100, wdata=0x12341234, en pulses one cycle even with ms_allowin held 0 for 3 cycles.
- es_flush at E+10 of a div: es_valid=0 and es_div_busy=0 next cycle; a following add 1+1 completes with 2 in one cycle.
- div reaches DONE with ms_allowin=0 for 5 cycles: es_result stable, es_div_busy=1, no restart; releases one cycle after ms_allowin=1.

Source files
------------

// File: rtl/ex_stage_md_if.sv
// ----------------------------------------------------------------------------
// ex_stage_md_if
// Purpose : Bundles every DS->ES, ES->MS and ES->data-SRAM signal of the
//           execute stage so the stage and its neighbours connect through one
//           port. clk/resetn are not part of the bundle.
// Params  : DW - datapath width (32 or 64).
// Modports:
//   master - the surroundings (DS, MS, flush source, SRAM observer): drives
//            ds_*, ms_allowin, es_flush; receives everything ES produces.
//   slave  - the execute stage itself.
// Signals : ms_allowin, es_allowin, ds_to_es_valid, ds_op[3:0], ds_src1/2,
//           ds_store_data, ds_mem_we, ds_res_from_mem, ds_mem_size[1:0],
//           ds_rf_we, ds_rf_waddr[4:0], ds_pc[31:0], es_flush,
//           es_to_ms_valid, es_result, es_rf_we, es_rf_waddr, es_res_from_mem,
//           es_pc, es_div_busy, data_sram_en/we/addr/wdata,
//           es_ale (only when EX_ALE_EN is defined).
// ----------------------------------------------------------------------------
interface ex_stage_md_if #(
  parameter int DW = 32
);
  // DS -> ES
  logic              ds_to_es_valid;
  logic [3:0]        ds_op;
  logic [DW-1:0]     ds_src1;
  logic [DW-1:0]     ds_src2;
  logic [DW-1:0]     ds_store_data;
  logic              ds_mem_we;
  logic              ds_res_from_mem;
  logic [1:0]        ds_mem_size;
  logic              ds_rf_we;
  logic [4:0]        ds_rf_waddr;
  logic [31:0]       ds_pc;
  logic              es_allowin;
  // MS / control -> ES
  logic              ms_allowin;
  logic              es_flush;
  // ES -> MS
  logic              es_to_ms_valid;
  logic [DW-1:0]     es_result;
  logic              es_rf_we;
  logic [4:0]        es_rf_waddr;
  logic              es_res_from_mem;
  logic [31:0]       es_pc;
  logic              es_div_busy;
  // ES -> data SRAM
  logic              data_sram_en;
  logic [DW/8-1:0]   data_sram_we;
  logic [31:0]       data_sram_addr;
  logic [DW-1:0]     data_sram_wdata;
`ifdef EX_ALE_EN
  logic              es_ale;
`endif

  modport master (
`ifdef EX_ALE_EN
    input  es_ale,
`endif
    output ds_to_es_valid, ds_op, ds_src1, ds_src2, ds_store_data,
           ds_mem_we, ds_res_from_mem, ds_mem_size, ds_rf_we, ds_rf_waddr,
           ds_pc, ms_allowin, es_flush,
    input  es_allowin, es_to_ms_valid, es_result, es_rf_we, es_rf_waddr,
           es_res_from_mem, es_pc, es_div_busy,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

  modport slave (
`ifdef EX_ALE_EN
    output es_ale,
`endif
    input  ds_to_es_valid, ds_op, ds_src1, ds_src2, ds_store_data,
           ds_mem_we, ds_res_from_mem, ds_mem_size, ds_rf_we, ds_rf_waddr,
           ds_pc, ms_allowin, es_flush,
    output es_allowin, es_to_ms_valid, es_result, es_rf_we, es_rf_waddr,
           es_res_from_mem, es_pc, es_div_busy,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/ex_stage_md.sv
// ----------------------------------------------------------------------------
// ex_stage_md
// Purpose : Execute stage of the in-order scalar pipeline (between DS and MS).
//           Latches one instruction per handshake, evaluates integer ALU ops
//           in one cycle, runs div/divu/mod/modu on a radix-2 restoring
//           divider (stalling the pipe until done) and drives the data SRAM
//           with sub-word byte enables and lane-replicated write data.
// Params  : DW       - datapath width, 32 or 64.
//           DIV_EN_W - 1 builds the divider; 0 makes div/mod return 0 at once.
// Macro   : EX_ALE_EN - when defined, adds output es_ale (misaligned mem
//           access); such an access gets no SRAM enable and no writeback but
//           still passes to MS.
// Ports   : clk     - clock
//           resetn  - asynchronous active-low reset
//           bus     - ex_stage_md_if.slave (handshake, operands, results,
//                     data SRAM request)
// ----------------------------------------------------------------------------
module ex_stage_md #(
  parameter int DW       = 32,
  parameter int DIV_EN_W = 1
) (
  input  logic         clk,
  input  logic         resetn,
  ex_stage_md_if.slave bus
);

  localparam int NB  = DW / 8;
  localparam int SHW = $clog2(DW);

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  logic            r_es_valid;
  logic [3:0]      r_op;
  logic [DW-1:0]   r_src1;
  logic [DW-1:0]   r_src2;
  logic [DW-1:0]   r_store_data;
  logic            r_mem_we;
  logic            r_res_from_mem;
  logic [1:0]      r_mem_size;
  logic            r_rf_we;
  logic [4:0]      r_rf_waddr;
  logic [31:0]     r_pc;
  logic            r_mem_issued;

  logic            w_is_div;
  logic            w_is_mem;
  logic            w_ready_go;
  logic            w_es_allowin;
  logic            w_load;
  logic            w_to_ms_valid;
  logic            w_sram_fire;
  logic            w_sram_en;
  logic            w_ale;

  logic            w_div_busy;
  logic            w_div_done;
  logic [DW-1:0]   w_div_res;

  assign w_is_div = (r_op >= 4'd10) && (r_op <= 4'd13);
  assign w_is_mem = r_mem_we | r_res_from_mem;

  // Only a divide can hold the stage; everything else finishes in one cycle.
  assign w_ready_go    = !w_is_div | w_div_done;
  // A flush blocks loading in the same cycle so the kill always wins.
  assign w_es_allowin  = !bus.es_flush & (!r_es_valid | (w_ready_go & bus.ms_allowin));
  assign w_load        = bus.ds_to_es_valid & w_es_allowin;
  assign w_to_ms_valid = r_es_valid & w_ready_go & !bus.es_flush;

  // The SRAM request fires once per instruction; r_mem_issued suppresses a
  // second write while MS stalls the instruction in this stage.
  assign w_sram_fire = r_es_valid & w_is_mem & !bus.es_flush & !r_mem_issued;
  assign w_sram_en   = w_sram_fire & !w_ale;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_es_valid     <= 1'b0;
      r_op           <= '0;
      r_src1         <= '0;
      r_src2         <= '0;
      r_store_data   <= '0;
      r_mem_we       <= 1'b0;
      r_res_from_mem <= 1'b0;
      r_mem_size     <= '0;
      r_rf_we        <= 1'b0;
      r_rf_waddr     <= '0;
      r_pc           <= '0;
      r_mem_issued   <= 1'b0;
    end else begin
      if (bus.es_flush) begin
        r_es_valid <= 1'b0;
      end else if (w_es_allowin) begin
        r_es_valid <= bus.ds_to_es_valid;
      end

      if (w_load) begin
        r_op           <= bus.ds_op;
        r_src1         <= bus.ds_src1;
        r_src2         <= bus.ds_src2;
        r_store_data   <= bus.ds_store_data;
        r_mem_we       <= bus.ds_mem_we;
        r_res_from_mem <= bus.ds_res_from_mem;
        r_mem_size     <= bus.ds_mem_size;
        r_rf_we        <= bus.ds_rf_we;
        r_rf_waddr     <= bus.ds_rf_waddr;
        r_pc           <= bus.ds_pc;
        r_mem_issued   <= 1'b0;
      end else if (w_sram_fire) begin
        r_mem_issued   <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Single-cycle ALU
  // --------------------------------------------------------------------------
  logic [DW-1:0]   w_sum;
  logic [DW-1:0]   w_diff;
  logic [SHW-1:0]  w_shamt;
  logic            w_slt;
  logic            w_sltu;
  logic [DW-1:0]   w_alu_res;

  assign w_sum   = r_src1 + r_src2;
  assign w_diff  = r_src1 - r_src2;
  assign w_shamt = r_src2[SHW-1:0];
  assign w_slt   = $signed(r_src1) < $signed(r_src2);
  assign w_sltu  = r_src1 < r_src2;

  always_comb begin
    w_alu_res = w_sum;
    case (r_op)
      4'd1:    w_alu_res = w_diff;
      4'd2:    w_alu_res = r_src1 & r_src2;
      4'd3:    w_alu_res = r_src1 | r_src2;
      4'd4:    w_alu_res = r_src1 ^ r_src2;
      4'd5:    w_alu_res = {{(DW-1){1'b0}}, w_slt};
      4'd6:    w_alu_res = {{(DW-1){1'b0}}, w_sltu};
      4'd7:    w_alu_res = r_src1 << w_shamt;
      4'd8:    w_alu_res = r_src1 >> w_shamt;
      4'd9:    w_alu_res = $signed(r_src1) >>> w_shamt;
      default: w_alu_res = w_sum;   // add, and ops 14/15 alias to add
    endcase
  end

  // --------------------------------------------------------------------------
  // Radix-2 restoring divider
  // --------------------------------------------------------------------------
  generate
    if (DIV_EN_W != 0) begin : g_div
      localparam int CW = $clog2(DW);

      typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
      } div_state_t;

      div_state_t      r_state;
      div_state_t      w_state_next;
      logic [CW-1:0]   r_cnt;
      logic [DW-1:0]   r_quo;        // shifts dividend out, quotient bits in
      logic [DW-1:0]   r_rem;
      logic [DW-1:0]   r_dvs;
      logic            r_q_neg;
      logic            r_r_neg;
      logic            r_dvs_zero;
      logic [DW-1:0]   r_res;

      logic            w_signed_op;
      logic            w_sign1;
      logic            w_sign2;
      logic [DW-1:0]   w_abs1;
      logic [DW-1:0]   w_abs2;
      logic            w_last;
      logic [DW:0]     w_rem_sh;
      logic [DW:0]     w_trial;
      logic            w_ge;
      logic [DW-1:0]   w_rem_nx;
      logic [DW-1:0]   w_quo_nx;
      logic [DW-1:0]   w_q_fin;
      logic [DW-1:0]   w_r_fin;
      logic            w_enter;

      assign w_signed_op = (r_op == 4'd10) || (r_op == 4'd12);
      assign w_sign1     = w_signed_op & r_src1[DW-1];
      assign w_sign2     = w_signed_op & r_src2[DW-1];
      assign w_abs1      = w_sign1 ? -r_src1 : r_src1;
      assign w_abs2      = w_sign2 ? -r_src2 : r_src2;
      assign w_last      = (r_cnt == CW'(DW - 1));
      assign w_enter     = (r_state == S_IDLE) && (w_state_next == S_BUSY);

      // One restoring step: shift in the next dividend bit, try to subtract.
      // Bit DW of the trial difference is the borrow.
      assign w_rem_sh = {r_rem, r_quo[DW-1]};
      assign w_trial  = w_rem_sh - {1'b0, r_dvs};
      assign w_ge     = !w_trial[DW];
      assign w_rem_nx = w_ge ? w_trial[DW-1:0] : w_rem_sh[DW-1:0];
      assign w_quo_nx = {r_quo[DW-2:0], w_ge};

      // Sign correction on the last step. |MIN|/1 = 0x80..0 negates to itself,
      // which gives MIN/-1 = MIN with remainder 0 without a special case.
      // Divide-by-zero is overridden: quotient all-ones, remainder = src1.
      assign w_q_fin = r_dvs_zero ? {DW{1'b1}} : (r_q_neg ? -w_quo_nx : w_quo_nx);
      assign w_r_fin = r_dvs_zero ? r_src1     : (r_r_neg ? -w_rem_nx : w_rem_nx);

      // State register
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_state <= S_IDLE;
        end else begin
          r_state <= w_state_next;
        end
      end

      // Next-state logic
      always_comb begin
        w_state_next = r_state;
        if (bus.es_flush) begin
          w_state_next = S_IDLE;
        end else begin
          case (r_state)
            S_IDLE:  if (r_es_valid && w_is_div) w_state_next = S_BUSY;
            S_BUSY:  if (w_last) w_state_next = S_DONE;
            // Held in DONE until MS takes the result; no restart meanwhile.
            S_DONE:  if (w_to_ms_valid && bus.ms_allowin) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
          endcase
        end
      end

      // Output logic
      always_comb begin
        w_div_busy = (r_state != S_IDLE);
        w_div_done = (r_state == S_DONE);
        w_div_res  = r_res;
      end

      // Divider datapath
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_cnt      <= '0;
          r_quo      <= '0;
          r_rem      <= '0;
          r_dvs      <= '0;
          r_q_neg    <= 1'b0;
          r_r_neg    <= 1'b0;
          r_dvs_zero <= 1'b0;
          r_res      <= '0;
        end else if (w_enter) begin
          r_cnt      <= '0;
          r_quo      <= w_abs1;
          r_rem      <= '0;
          r_dvs      <= w_abs2;
          r_q_neg    <= w_sign1 ^ w_sign2;
          r_r_neg    <= w_sign1;
          r_dvs_zero <= (r_src2 == '0);
        end else if (r_state == S_BUSY) begin
          r_cnt <= r_cnt + 1'b1;
          r_quo <= w_quo_nx;
          r_rem <= w_rem_nx;
          if (w_last) begin
            r_res <= ((r_op == 4'd10) || (r_op == 4'd11)) ? w_q_fin : w_r_fin;
          end
        end
      end
    end else begin : g_nodiv
      // Without a divider, div/mod complete immediately with a zero result.
      assign w_div_busy = 1'b0;
      assign w_div_done = 1'b1;
      assign w_div_res  = '0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Data SRAM request
  // --------------------------------------------------------------------------
  logic [2:0]      w_lane;
  logic [NB-1:0]   w_be;
  logic [DW-1:0]   w_wdata;

  // Byte lane inside one SRAM word (only 2 bits meaningful when DW=32).
  assign w_lane = w_sum[2:0] & 3'(NB - 1);

  always_comb begin
    w_be    = '0;
    w_wdata = r_store_data;
    case (r_mem_size)
      2'd0: begin
        w_be    = NB'(16'h0001 << w_lane);
        w_wdata = {NB{r_store_data[7:0]}};
      end
      2'd1: begin
        w_be    = NB'(16'h0003 << {w_lane[2:1], 1'b0});
        w_wdata = {(NB/2){r_store_data[15:0]}};
      end
      2'd2: begin
        w_be    = NB'(16'h000F << {w_lane[2], 2'b00});
        w_wdata = {(NB/4){r_store_data[31:0]}};
      end
      default: begin
        w_be    = '1;
        w_wdata = r_store_data;
      end
    endcase
  end

`ifdef EX_ALE_EN
  logic w_misaligned;

  always_comb begin
    w_misaligned = 1'b0;
    case (r_mem_size)
      2'd1:    w_misaligned = w_sum[0];
      2'd2:    w_misaligned = |w_sum[1:0];
      2'd3:    w_misaligned = |w_sum[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_ale      = r_es_valid & w_is_mem & w_misaligned;
  assign bus.es_ale = w_ale;
`else
  assign w_ale = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.es_allowin      = w_es_allowin;
  assign bus.es_to_ms_valid  = w_to_ms_valid;
  assign bus.es_result       = w_is_mem ? w_sum : (w_is_div ? w_div_res : w_alu_res);
  assign bus.es_rf_we        = r_es_valid & r_rf_we & !w_ale;
  assign bus.es_rf_waddr     = r_rf_waddr;
  assign bus.es_res_from_mem = r_res_from_mem;
  assign bus.es_pc           = r_pc;
  assign bus.es_div_busy     = w_div_busy;
  assign bus.data_sram_en    = w_sram_en;
  assign bus.data_sram_we    = (w_sram_en & r_mem_we) ? w_be : '0;
  assign bus.data_sram_addr  = w_sum[31:0];
  assign bus.data_sram_wdata = w_wdata;

endmodule

// File: tb/tb_ex_stage_md.sv
module tb_ex_stage_md;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  ex_stage_md_if #(.DW(DW)) bus ();

  ex_stage_md #(.DW(DW), .DIV_EN_W(1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  string       tag_q[$];
  logic [63:0] mon_exp;
  string       mon_tag;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  // Offer a register-writing ALU-style instruction from DS.
  task automatic set_ds(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2);
    bus.ds_to_es_valid  = 1'b1;
    bus.ds_op           = op;
    bus.ds_src1         = s1;
    bus.ds_src2         = s2;
    bus.ds_store_data   = '0;
    bus.ds_mem_we       = 1'b0;
    bus.ds_res_from_mem = 1'b0;
    bus.ds_mem_size     = 2'd2;
    bus.ds_rf_we        = 1'b1;
    bus.ds_rf_waddr     = 5'd3;
    bus.ds_pc           = bus.ds_pc + 32'd4;
  endtask

  // Called at posedge+1: offer, let it load on the next edge, then withdraw.
  task automatic send(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                      input logic [63:0] exp, input string tag);
    set_ds(op, s1, s2);
    push(exp, tag);
    @(posedge clk);
    #1 bus.ds_to_es_valid = 1'b0;
  endtask

  // Cycles from the load edge until es_to_ms_valid is seen (0 = same cycle).
  task automatic wait_out(output int lat);
    lat = 0;
    @(negedge clk);
    while (bus.es_to_ms_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Scoreboard: pop one expected result per accepted ES->MS transfer.
  always @(negedge clk) begin
    if (resetn === 1'b1 && bus.es_to_ms_valid === 1'b1 && bus.ms_allowin === 1'b1) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_unexpected: observed result 0x%0h expected no transfer", bus.es_result);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        $display("tx %-16s pc=0x%08h result=0x%08h", mon_tag, bus.es_pc, bus.es_result);
        chk(mon_tag, 64'(bus.es_result), mon_exp);
      end
    end
  end

  initial begin
    int lat;
    int busy_cnt;
    int stall_bad;
    int en_cnt;

    resetn              = 1'b0;
    bus.ds_to_es_valid  = 1'b0;
    bus.ds_op           = '0;
    bus.ds_src1         = '0;
    bus.ds_src2         = '0;
    bus.ds_store_data   = '0;
    bus.ds_mem_we       = 1'b0;
    bus.ds_res_from_mem = 1'b0;
    bus.ds_mem_size     = '0;
    bus.ds_rf_we        = 1'b0;
    bus.ds_rf_waddr     = '0;
    bus.ds_pc           = 32'h0000_1000;
    bus.ms_allowin      = 1'b1;
    bus.es_flush        = 1'b0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_allowin",    64'(bus.es_allowin), 1);
    chk("rst_to_ms",      64'(bus.es_to_ms_valid), 0);
    chk("rst_result",     64'(bus.es_result), 0);
    chk("rst_div_busy",   64'(bus.es_div_busy), 0);
    chk("rst_sram_en",    64'(bus.data_sram_en), 0);
    chk("rst_sram_we",    64'(bus.data_sram_we), 0);
    chk("rst_sram_wdata", 64'(bus.data_sram_wdata), 0);
    chk("rst_rf_we",      64'(bus.es_rf_we), 0);
    chk("rst_pc",         64'(bus.es_pc), 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // ---- back-to-back add / sub ----
    set_ds(4'd0, 32'd5, 32'd7);
    push(64'd12, "add_5_7");
    @(posedge clk); #1;
    set_ds(4'd1, 32'd3, 32'd5);
    push(64'hFFFF_FFFE, "sub_3_5");
    @(negedge clk);
    chk("add_to_ms_first", 64'(bus.es_to_ms_valid), 1);
    chk("add_rf_we",       64'(bus.es_rf_we), 1);
    chk("add_allowin",     64'(bus.es_allowin), 1);
    @(posedge clk); #1;
    bus.ds_to_es_valid = 1'b0;
    @(negedge clk);
    chk("sub_to_ms_next", 64'(bus.es_to_ms_valid), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("alu_drained", 64'(bus.es_to_ms_valid), 0);

    // ---- slt / sra ----
    @(posedge clk); #1;
    send(4'd5, 32'hFFFF_FFFF, 32'd1, 64'd1, "slt_m1_1");
    wait_out(lat);
    chk("slt_lat", 64'(lat), 0);
    @(posedge clk); #1;
    send(4'd9, 32'h8000_0000, 32'h0000_0024, 64'hF800_0000, "sra_min_4");
    wait_out(lat);
    chk("sra_lat", 64'(lat), 0);

    // ---- div -7/2 with cycle-exact timing ----
    @(posedge clk); #1;
    send(4'd10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFD, "div_m7_2");
    @(negedge clk);
    chk("divE_busy",    64'(bus.es_div_busy), 0);
    chk("divE_allowin", 64'(bus.es_allowin), 0);
    chk("divE_to_ms",   64'(bus.es_to_ms_valid), 0);
    busy_cnt  = 0;
    stall_bad = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (bus.es_div_busy === 1'b1) busy_cnt++;
      if (bus.es_to_ms_valid !== 1'b0 || bus.es_allowin !== 1'b0) stall_bad++;
    end
    chk("div_busy_cycles", 64'(busy_cnt), 32);
    chk("div_stall_held",  64'(stall_bad), 0);
    @(negedge clk);
    chk("div_out_E33",     64'(bus.es_to_ms_valid), 1);
    chk("div_allowin_E33", 64'(bus.es_allowin), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("div_back_idle", 64'(bus.es_div_busy), 0);

    // ---- remaining divide cases ----
    @(posedge clk); #1;
    send(4'd12, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF, "mod_m7_2");
    wait_out(lat);
    chk("mod_lat", 64'(lat), 33);
    @(posedge clk); #1;
    send(4'd11, 32'h10, 32'd0, 64'hFFFF_FFFF, "divu_16_0");
    wait_out(lat);
    chk("divu0_lat", 64'(lat), 33);
    @(posedge clk); #1;
    send(4'd13, 32'h10, 32'd0, 64'h10, "modu_16_0");
    wait_out(lat);
    chk("modu0_lat", 64'(lat), 33);
    @(posedge clk); #1;
    send(4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h8000_0000, "div_min_m1");
    wait_out(lat);
    chk("divmin_lat", 64'(lat), 33);
    @(posedge clk); #1;
    send(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0, "mod_min_m1");
    wait_out(lat);
    chk("modmin_lat", 64'(lat), 33);

    // ---- store half under a 3-cycle MS stall ----
    @(posedge clk); #1;
    set_ds(4'd0, 32'h1000, 32'h2);
    bus.ds_mem_we     = 1'b1;
    bus.ds_mem_size   = 2'd1;
    bus.ds_store_data = 32'hABCD_1234;
    bus.ds_rf_we      = 1'b0;
    bus.ms_allowin    = 1'b0;
    push(64'h1002, "sth_1002");
    @(posedge clk); #1;
    bus.ds_to_es_valid = 1'b0;
    @(negedge clk);
    en_cnt = int'(bus.data_sram_en);
    chk("sth_en",    64'(bus.data_sram_en), 1);
    chk("sth_we",    64'(bus.data_sram_we), 64'hC);
    chk("sth_wdata", 64'(bus.data_sram_wdata), 64'h1234_1234);
    chk("sth_addr",  64'(bus.data_sram_addr), 64'h1002);
    repeat (2) begin
      @(negedge clk);
      en_cnt += int'(bus.data_sram_en);
    end
    chk("sth_stalled_valid", 64'(bus.es_to_ms_valid), 1);
    @(posedge clk); #1;
    bus.ms_allowin = 1'b1;
    @(negedge clk);
    en_cnt += int'(bus.data_sram_en);
    chk("sth_en_pulses", 64'(en_cnt), 1);

    // ---- store byte ----
    @(posedge clk); #1;
    set_ds(4'd0, 32'h1000, 32'h3);
    bus.ds_mem_we     = 1'b1;
    bus.ds_mem_size   = 2'd0;
    bus.ds_store_data = 32'hCAFE_5577;
    bus.ds_rf_we      = 1'b0;
    push(64'h1003, "stb_1003");
    @(posedge clk); #1;
    bus.ds_to_es_valid = 1'b0;
    @(negedge clk);
    chk("stb_we",    64'(bus.data_sram_we), 64'h8);
    chk("stb_wdata", 64'(bus.data_sram_wdata), 64'h7777_7777);

    // ---- load word ----
    @(posedge clk); #1;
    set_ds(4'd0, 32'h2000, 32'h4);
    bus.ds_res_from_mem = 1'b1;
    bus.ds_mem_size     = 2'd2;
    push(64'h2004, "ldw_2004");
    @(posedge clk); #1;
    bus.ds_to_es_valid = 1'b0;
    @(negedge clk);
    chk("ldw_en",       64'(bus.data_sram_en), 1);
    chk("ldw_we",       64'(bus.data_sram_we), 0);
    chk("ldw_from_mem", 64'(bus.es_res_from_mem), 1);

    // ---- flush a divide at E+10 ----
    @(posedge clk); #1;
    set_ds(4'd10, 32'd100, 32'd7);   // killed, so nothing is expected from it
    @(posedge clk); #1;
    bus.ds_to_es_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 bus.es_flush = 1'b1;
    @(negedge clk);
    chk("flush_allowin_blocked", 64'(bus.es_allowin), 0);
    chk("flush_to_ms_blocked",   64'(bus.es_to_ms_valid), 0);
    @(posedge clk); #1;
    bus.es_flush = 1'b0;
    @(negedge clk);
    chk("flush_div_idle", 64'(bus.es_div_busy), 0);
    chk("flush_allowin",  64'(bus.es_allowin), 1);
    @(posedge clk); #1;
    send(4'd0, 32'd1, 32'd1, 64'd2, "add_after_flush");
    wait_out(lat);
    chk("add_after_flush_lat", 64'(lat), 0);

    // ---- divide finishing into a 5-cycle MS stall ----
    @(posedge clk); #1;
    bus.ms_allowin = 1'b0;
    send(4'd10, 32'd100, 32'd7, 64'd14, "div_100_7_hold");
    wait_out(lat);
    chk("hold_lat",    64'(lat), 33);
    chk("hold_result", 64'(bus.es_result), 64'd14);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold_result_stable", 64'(bus.es_result), 64'd14);
      chk("hold_busy",          64'(bus.es_div_busy), 1);
      chk("hold_to_ms",         64'(bus.es_to_ms_valid), 1);
    end
    @(posedge clk); #1;
    bus.ms_allowin = 1'b1;
    @(negedge clk);
    chk("hold_release_busy", 64'(bus.es_div_busy), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_released_busy", 64'(bus.es_div_busy), 0);
    chk("hold_released_out",  64'(bus.es_to_ms_valid), 0);

    // ---- every pushed result must have been seen ----
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    chk("sb_drained", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
